// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default constants for the memory arbiter
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W      = 13;
    localparam int MEM_ARB_DATA_W      = 8;
    localparam int MEM_ARB_TIMEOUT_CYC = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DT = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and shared-memory signals of the memory arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dt_req;
    logic              dt_we;
    logic [ADDR_W-1:0] dt_addr;
    logic [DATA_W-1:0] dt_wdata;
    logic              dt_gnt;
    logic              dt_done;
    logic [DATA_W-1:0] dt_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              MEM_read;
    logic              MEM_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              err;

    modport slave (
        input  if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata, mem_ready,
        output if_gnt, if_done, if_rdata, dt_gnt, dt_done, dt_rdata,
        output mem_addr, mem_wdata, MEM_read, MEM_write, err
    );

    modport master (
        output if_req, if_addr, dt_req, dt_we, dt_addr, dt_wdata, mem_rdata, mem_ready,
        input  if_gnt, if_done, if_rdata, dt_gnt, dt_done, dt_rdata,
        input  mem_addr, mem_wdata, MEM_read, MEM_write, err
    );

endinterface

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - 8-bit busy-cycle counter flagging the final cycle before abort
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = MEM_ARB_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the LIMIT-th stalled cycle so a ready in that same cycle still wins.
    assign expire = enable && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one shared memory port with busy timeout
// MEM_ARB_RR_EN selects round-robin on contention; otherwise data always beats fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = MEM_ARB_ADDR_W,
    parameter int DATA_W      = MEM_ARB_DATA_W,
    parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dt_rdata_q, dt_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dt_done_q, dt_done_d;
    logic              err_q, err_d;
    logic              grant_if, grant_dt;
    logic              cnt_en, expire;

`ifdef MEM_ARB_RR_EN
    arb_owner_e        last_q, last_d;
`endif

    // Grants are combinational so the requester sees them in its request cycle.
    always_comb begin
        grant_if = 1'b0;
        grant_dt = 1'b0;
        if (state_q == IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
            if (bus.if_req && bus.dt_req) begin
                grant_if = (last_q == OWN_DT);
                grant_dt = (last_q == OWN_IF);
            end else begin
                grant_if = bus.if_req;
                grant_dt = bus.dt_req;
            end
`else
            grant_dt = bus.dt_req;
            grant_if = bus.if_req && !bus.dt_req;
`endif
        end
    end

    assign cnt_en = (state_q != IDLE) && !bus.mem_ready;

    arb_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_if || grant_dt),
        .enable (cnt_en),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dt_rdata_d = dt_rdata_q;
        if_done_d  = 1'b0;
        dt_done_d  = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_dt) begin
                    state_d = BUSY_DT;
                    addr_d  = bus.dt_addr;
                    we_d    = bus.dt_we;
                    wdata_d = bus.dt_wdata;
                end else if (grant_if) begin
                    state_d = BUSY_IF;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end else if (expire) begin
                    state_d   = IDLE;
                    if_done_d = 1'b1;
                    err_d     = 1'b1;
                end
            end
            BUSY_DT: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    dt_done_d = 1'b1;
                    if (!we_q) begin
                        dt_rdata_d = bus.mem_rdata;
                    end
                end else if (expire) begin
                    state_d   = IDLE;
                    dt_done_d = 1'b1;
                    err_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (grant_dt) begin
            last_d = OWN_DT;
        end else if (grant_if) begin
            last_d = OWN_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_DT;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dt_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dt_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dt_rdata_q <= dt_rdata_d;
            if_done_q  <= if_done_d;
            dt_done_q  <= dt_done_d;
            err_q      <= err_d;
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dt_gnt    = grant_dt;
    assign bus.if_done   = if_done_q;
    assign bus.dt_done   = dt_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dt_rdata  = dt_rdata_q;
    assign bus.err       = err_q;
    assign bus.MEM_read  = (state_q == BUSY_IF) || (state_q == BUSY_DT && !we_q);
    assign bus.MEM_write = (state_q == BUSY_DT) && we_q;
    assign bus.mem_addr  = (state_q != IDLE) ? addr_q : '0;
    assign bus.mem_wdata = (state_q == BUSY_DT) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending requests, last winner, per-requester read data, expected done pulse.
    bit            want_if, want_dt;
    logic [AW-1:0] w_if_addr, w_dt_addr;
    bit            w_dt_we;
    logic [DW-1:0] w_dt_wdata;
    logic [DW-1:0] m_if_rdata, m_dt_rdata;
    bit            last_dt;
    bit            p_if_done, p_dt_done, p_err;
    int            win_log[$];
    int            exp_seq[3];
    int            w;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic new_req_if(input logic [AW-1:0] a);
        if (!want_if) begin
            want_if   = 1'b1;
            w_if_addr = a;
        end
    endtask

    task automatic new_req_dt(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!want_dt) begin
            want_dt    = 1'b1;
            w_dt_we    = we;
            w_dt_addr  = a;
            w_dt_wdata = d;
        end
    endtask

    function automatic int pick_winner();
        if (want_if && want_dt) begin
`ifdef MEM_ARB_RR_EN
            return last_dt ? 1 : 2;
`else
            return 2;
`endif
        end
        if (want_dt) return 2;
        if (want_if) return 1;
        return 0;
    endfunction

    task automatic drive_reqs();
        bus.if_req   = want_if;
        bus.if_addr  = want_if ? w_if_addr : AW'($urandom);
        bus.dt_req   = want_dt;
        bus.dt_we    = want_dt ? w_dt_we : 1'($urandom);
        bus.dt_addr  = want_dt ? w_dt_addr : AW'($urandom);
        bus.dt_wdata = want_dt ? w_dt_wdata : DW'($urandom);
    endtask

    task automatic check_idle_outputs();
        check_eq("if_done", bus.if_done, p_if_done);
        check_eq("dt_done", bus.dt_done, p_dt_done);
        check_eq("err", bus.err, p_err);
        check_eq("if_rdata", bus.if_rdata, m_if_rdata);
        check_eq("dt_rdata", bus.dt_rdata, m_dt_rdata);
        check_eq("idle_MEM_read", bus.MEM_read, 0);
        check_eq("idle_MEM_write", bus.MEM_write, 0);
        check_eq("idle_mem_addr", bus.mem_addr, 0);
        check_eq("idle_mem_wdata", bus.mem_wdata, 0);
        p_if_done = 1'b0;
        p_dt_done = 1'b0;
        p_err     = 1'b0;
    endtask

    // One IDLE cycle (entered at posedge+1) plus the whole transaction it grants, if any.
    // ready_at: busy cycle index carrying mem_ready; 0 or >TO means the memory never answers.
    task automatic run_step(input int ready_at, input logic [DW-1:0] rd_val, output int winner);
        int            end_k;
        bit            is_err, o_dt, o_we;
        logic [AW-1:0] o_addr;
        logic [DW-1:0] o_wd;
        drive_reqs();
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = DW'($urandom);
        #4;
        check_idle_outputs();
        winner = pick_winner();
        check_eq("if_gnt", bus.if_gnt, winner == 1);
        check_eq("dt_gnt", bus.dt_gnt, winner == 2);
        if (winner == 0) begin
            @(posedge clk);
            #1;
            return;
        end
        o_dt    = (winner == 2);
        last_dt = o_dt;
        if (o_dt) begin
            want_dt = 1'b0;
            o_we    = w_dt_we;
            o_addr  = w_dt_addr;
            o_wd    = w_dt_wdata;
        end else begin
            want_if = 1'b0;
            o_we    = 1'b0;
            o_addr  = w_if_addr;
            o_wd    = '0;
        end
        is_err = (ready_at < 1) || (ready_at > TO);
        end_k  = is_err ? TO : ready_at;
        @(posedge clk);
        #1;
        drive_reqs();
        for (int k = 1; k <= end_k; k++) begin
            bus.mem_ready = (k == ready_at);
            bus.mem_rdata = (k == ready_at) ? rd_val : DW'($urandom);
            #4;
            check_eq("busy_if_gnt", bus.if_gnt, 0);
            check_eq("busy_dt_gnt", bus.dt_gnt, 0);
            check_eq("busy_if_done", bus.if_done, 0);
            check_eq("busy_dt_done", bus.dt_done, 0);
            check_eq("busy_err", bus.err, 0);
            check_eq("MEM_read", bus.MEM_read, !o_we);
            check_eq("MEM_write", bus.MEM_write, o_we);
            check_eq("mem_addr", bus.mem_addr, o_addr);
            if (o_dt) check_eq("mem_wdata", bus.mem_wdata, o_wd);
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        p_if_done = !o_dt;
        p_dt_done = o_dt;
        p_err     = is_err;
        if (!is_err && !o_we) begin
            if (o_dt) m_dt_rdata = rd_val;
            else      m_if_rdata = rd_val;
        end
    endtask

    task automatic model_reset();
        want_if    = 1'b0;
        want_dt    = 1'b0;
        m_if_rdata = '0;
        m_dt_rdata = '0;
        last_dt    = 1'b1;
        p_if_done  = 1'b0;
        p_dt_done  = 1'b0;
        p_err      = 1'b0;
    endtask

    initial begin
        model_reset();
        rst           = 1'b1;
        bus.if_req    = 1'b1;
        bus.dt_req    = 1'b1;
        bus.if_addr   = '0;
        bus.dt_addr   = '0;
        bus.dt_we     = 1'b1;
        bus.dt_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        check_eq("rst_if_gnt", bus.if_gnt, 0);
        check_eq("rst_dt_gnt", bus.dt_gnt, 0);
        check_eq("rst_MEM_write", bus.MEM_write, 0);
        check_eq("rst_MEM_read", bus.MEM_read, 0);
        @(posedge clk);
        #1;
        bus.if_req    = 1'b0;
        bus.dt_req    = 1'b0;
        bus.mem_ready = 1'b0;
        rst           = 1'b0;

        // Single fetch with one-cycle memory latency
        new_req_if(13'h0A0);
        run_step(1, 8'h5C, w);
        check_eq("fetch_winner", w, 1);
        run_step(1, 8'h00, w);
        check_eq("fetch_if_rdata", bus.if_rdata, 8'h5C);

        // Data write leaves dt_rdata alone
        new_req_dt(1'b1, 13'h1FF, 8'hA5);
        run_step(1, 8'h33, w);
        run_step(1, 8'h00, w);
        check_eq("write_dt_rdata", bus.dt_rdata, 8'h00);

        // Three contended grants
`ifdef MEM_ARB_RR_EN
        exp_seq = '{1, 2, 1};
`else
        exp_seq = '{2, 2, 2};
`endif
        for (int i = 0; i < 3; i++) begin
            new_req_if(AW'($urandom));
            new_req_dt(1'($urandom), AW'($urandom), DW'($urandom));
            run_step(1, DW'($urandom), w);
            win_log.push_back(w);
        end
        for (int i = 0; i < 3; i++) check_eq($sformatf("contend_win%0d", i), win_log[i], exp_seq[i]);
        repeat (3) run_step(1, DW'($urandom), w);

        // Fetch timeout, then data read answered exactly at the timeout cycle
        new_req_if(AW'($urandom));
        run_step(0, 8'h00, w);
        run_step(1, 8'h00, w);
        new_req_dt(1'b0, AW'($urandom), 8'h00);
        run_step(TO, 8'h7E, w);
        run_step(1, 8'h00, w);
        check_eq("edge_dt_rdata", bus.dt_rdata, 8'h7E);

        // Reset during a data write
        new_req_dt(1'b1, 13'h0155, 8'h3C);
        drive_reqs();
        #4;
        check_idle_outputs();
        check_eq("pre_rst_dt_gnt", bus.dt_gnt, 1);
        @(posedge clk);
        #1;
        want_dt = 1'b0;
        drive_reqs();
        #3;
        check_eq("pre_rst_MEM_write", bus.MEM_write, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_MEM_write", bus.MEM_write, 0);
        check_eq("rst_mid_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mid_dt_rdata", bus.dt_rdata, 0);
        check_eq("rst_mid_if_rdata", bus.if_rdata, 0);
        @(posedge clk);
        #1;
        check_eq("rst_mid_dt_done", bus.dt_done, 0);
        rst = 1'b0;
        model_reset();
        new_req_if(AW'($urandom));
        run_step(2, DW'($urandom), w);
        check_eq("post_rst_winner", w, 1);

        for (int i = 0; i < 200; i++) begin
            int ra;
            if ($urandom_range(0, 2) != 0) new_req_if(AW'($urandom));
            if ($urandom_range(0, 2) != 0) new_req_dt(1'($urandom), AW'($urandom), DW'($urandom));
            case ($urandom_range(0, 9))
                0:       ra = 0;
                1:       ra = TO;
                2:       ra = TO + 1;
                default: ra = $urandom_range(1, 4);
            endcase
            run_step(ra, DW'($urandom), w);
        end
        repeat (3) run_step(1, DW'($urandom), w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
